// File: rtl/divider_arbiter_pkg.sv
// Shared types for the divider arbiter: FSM encoding and the quotient
// reported when a request arrives with a zero divisor.
package divider_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  // Sliced down to WIDTH at the point of use.
  localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/divider_arbiter_divider.sv
// Iterative restoring divider: one quotient bit per cycle, result strobed
// on data_valid_out WIDTH+2 cycles after the data_valid_in cycle.
module divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             data_valid_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             data_valid_out,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             running_q;
  logic             finish_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // The top bit of trial is the borrow: clear means the divisor fits.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dsr_q};
    fits     = ~trial[WIDTH];
    rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      running_q      <= 1'b0;
      finish_q       <= 1'b0;
      cnt_q          <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      dsr_q          <= '0;
      data_valid_out <= 1'b0;
      quotient_out   <= '0;
      remainder_out  <= '0;
    end else begin
      data_valid_out <= 1'b0;
      finish_q       <= 1'b0;
      if (finish_q) begin
        data_valid_out <= 1'b1;
        quotient_out   <= quo_q;
        remainder_out  <= rem_q;
      end
      if (running_q) begin
        rem_q <= rem_next;
        quo_q <= quo_next;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          running_q <= 1'b0;
          finish_q  <= 1'b1;
        end
      end else if (data_valid_in) begin
        running_q <= 1'b1;
        cnt_q     <= CNT_W'(WIDTH);
        rem_q     <= '0;
        quo_q     <= dividend_in;
        dsr_q     <= divisor_in;
      end
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin front end sharing one iterative divider among NUM_REQ
// requesters; zero divisors are answered without touching the divider.
module divider_arbiter
  import divider_arbiter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [NUM_REQ-1:0]         req_valid_in,
  input  logic [NUM_REQ*WIDTH-1:0]   dividend_in,
  input  logic [NUM_REQ*WIDTH-1:0]   divisor_in,
  output logic [NUM_REQ-1:0]         req_ready_out,
  output logic [NUM_REQ-1:0]         resp_valid_out,
  output logic [$clog2(NUM_REQ)-1:0] resp_id_out,
  output logic [WIDTH-1:0]           quotient_out,
  output logic [WIDTH-1:0]           remainder_out,
  output logic                       div_by_zero_out,
  output logic                       busy_out
);

  localparam int ID_W = $clog2(NUM_REQ);

  // Handshake: a request transfers in the cycle where req_valid_in[i] and
  // req_ready_out[i] are both high; ready is only ever raised in IDLE.
  state_t           state_q;
  logic [ID_W-1:0]  last_grant_q;
  logic [ID_W-1:0]  grant_id_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;

  logic             found;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  cand;
  int               idx;
  logic [WIDTH-1:0] win_dividend;
  logic [WIDTH-1:0] win_divisor;

  logic             div_start;
  logic             div_valid;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  // Search upward from the requester after the last grant, wrapping.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    idx    = 0;
    cand   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(last_grant_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!found && req_valid_in[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
  end

  assign win_dividend  = dividend_in[win_id*WIDTH +: WIDTH];
  assign win_divisor   = divisor_in[win_id*WIDTH +: WIDTH];
  assign req_ready_out = (state_q == IDLE && !rst_in && found)
                         ? (NUM_REQ'(1) << win_id) : '0;
  assign busy_out      = (state_q != IDLE);
  assign div_start     = (state_q == ISSUE);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= IDLE;
      last_grant_q    <= ID_W'(NUM_REQ - 1);
      grant_id_q      <= '0;
      dvd_q           <= '0;
      dsr_q           <= '0;
      resp_valid_out  <= '0;
      resp_id_out     <= '0;
      quotient_out    <= '0;
      remainder_out   <= '0;
      div_by_zero_out <= 1'b0;
    end else begin
      resp_valid_out <= '0;
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_id_q   <= win_id;
            last_grant_q <= win_id;
            dvd_q        <= win_dividend;
            dsr_q        <= win_divisor;
            if (win_divisor == '0) begin
              state_q         <= RESPOND;
              resp_valid_out  <= NUM_REQ'(1) << win_id;
              resp_id_out     <= win_id;
              quotient_out    <= DBZ_QUOTIENT[WIDTH-1:0];
              remainder_out   <= win_dividend;
              div_by_zero_out <= 1'b1;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (div_valid) begin
            state_q         <= RESPOND;
            resp_valid_out  <= NUM_REQ'(1) << grant_id_q;
            resp_id_out     <= grant_id_q;
            quotient_out    <= div_quo;
            remainder_out   <= div_rem;
            div_by_zero_out <= 1'b0;
          end
        end
        RESPOND: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .data_valid_in (div_start),
    .dividend_in   (dvd_q),
    .divisor_in    (dsr_q),
    .data_valid_out(div_valid),
    .quotient_out  (div_quo),
    .remainder_out (div_rem)
  );

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed cycle-exact bench for divider_arbiter (WIDTH=8, NUM_REQ=4).
module tb_divider_arbiter;

  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;

  logic                     clk_in;
  logic                     rst_in;
  logic [NUM_REQ-1:0]       req_valid_in;
  logic [NUM_REQ*WIDTH-1:0] dividend_in;
  logic [NUM_REQ*WIDTH-1:0] divisor_in;
  logic [NUM_REQ-1:0]       req_ready_out;
  logic [NUM_REQ-1:0]       resp_valid_out;
  logic [1:0]               resp_id_out;
  logic [WIDTH-1:0]         quotient_out;
  logic [WIDTH-1:0]         remainder_out;
  logic                     div_by_zero_out;
  logic                     busy_out;

  int checks = 0;
  int errors = 0;

  divider_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .req_valid_in   (req_valid_in),
    .dividend_in    (dividend_in),
    .divisor_in     (divisor_in),
    .req_ready_out  (req_ready_out),
    .resp_valid_out (resp_valid_out),
    .resp_id_out    (resp_id_out),
    .quotient_out   (quotient_out),
    .remainder_out  (remainder_out),
    .div_by_zero_out(div_by_zero_out),
    .busy_out       (busy_out)
  );

  // Clock
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Driver helpers: advance n cycles and land just after the edge.
  task automatic adv(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_resp(input string tag, input logic [3:0] vld, input logic [1:0] id,
                            input logic [7:0] q, input logic [7:0] r, input logic dbz);
    check({tag, "_valid"}, 32'(resp_valid_out), 32'(vld));
    check({tag, "_id"},    32'(resp_id_out),    32'(id));
    check({tag, "_q"},     32'(quotient_out),   32'(q));
    check({tag, "_r"},     32'(remainder_out),  32'(r));
    check({tag, "_dbz"},   32'(div_by_zero_out), 32'(dbz));
  endtask

  logic [7:0] rr_q [4] = '{8'd10, 8'd11, 8'd16, 8'd255};
  logic [7:0] rr_r [4] = '{8'd0,  8'd0,  8'd2,  8'd0};
  logic [3:0] seen;

  initial begin
    rst_in       = 1'b1;
    req_valid_in = '0;
    dividend_in  = '0;
    divisor_in   = '0;

    // Reset state
    adv(2);
    @(negedge clk_in);
    check_resp("reset", 4'b0000, 2'd0, 8'd0, 8'd0, 1'b0);
    check("reset_busy", 32'(busy_out), 32'd0);
    check("reset_ready", 32'(req_ready_out), 32'd0);

    // Single request: requester 2 sends 200/7
    adv(1);
    rst_in       = 1'b0;
    req_valid_in = 4'b0100;
    dividend_in  = {8'd0, 8'd200, 8'd0, 8'd0};
    divisor_in   = {8'd0, 8'd7, 8'd0, 8'd0};
    @(negedge clk_in);
    check("single_ready", 32'(req_ready_out), 32'h4);
    adv(1);
    req_valid_in = '0;
    @(negedge clk_in);
    check("single_busy", 32'(busy_out), 32'd1);
    check("single_ready_busy", 32'(req_ready_out), 32'd0);
    adv(10);
    @(negedge clk_in);
    check("single_early", 32'(resp_valid_out), 32'd0);
    adv(1);
    @(negedge clk_in);
    check_resp("single", 4'b0100, 2'd2, 8'd28, 8'd4, 1'b0);
    adv(1);
    @(negedge clk_in);
    check("single_strobe_end", 32'(resp_valid_out), 32'd0);
    check("single_q_held", 32'(quotient_out), 32'd28);
    check("single_idle", 32'(busy_out), 32'd0);

    // Round-robin: all four hold valid from reset
    rst_in = 1'b1;
    adv(1);
    rst_in       = 1'b0;
    req_valid_in = 4'b1111;
    dividend_in  = {8'd255, 8'd50, 8'd99, 8'd100};
    divisor_in   = {8'd1, 8'd3, 8'd9, 8'd10};
    for (int g = 0; g < 5; g++) begin
      @(negedge clk_in);
      check($sformatf("rr%0d_ready", g), 32'(req_ready_out), 32'(4'b0001 << (g % 4)));
      adv(1);
      if (g == 4) req_valid_in = '0;
      adv(11);
      @(negedge clk_in);
      check_resp($sformatf("rr%0d", g), 4'(4'b0001 << (g % 4)), 2'(g % 4),
                 rr_q[g % 4], rr_r[g % 4], 1'b0);
      adv(1);
    end

    // Divide by zero: requester 1 sends 37/0
    req_valid_in = 4'b0010;
    dividend_in  = {8'd0, 8'd0, 8'd37, 8'd0};
    divisor_in   = '0;
    @(negedge clk_in);
    check("dbz_ready", 32'(req_ready_out), 32'h2);
    adv(1);
    req_valid_in = '0;
    @(negedge clk_in);
    check_resp("dbz", 4'b0010, 2'd1, 8'd255, 8'd37, 1'b1);
    check("dbz_no_start", 32'(dut.div_start), 32'd0);
    adv(1);
    req_valid_in = 4'b0001;
    dividend_in  = {8'd0, 8'd0, 8'd0, 8'd20};
    divisor_in   = {8'd0, 8'd0, 8'd0, 8'd6};
    @(negedge clk_in);
    check("dbz_next_ready", 32'(req_ready_out), 32'h1);
    adv(1);
    req_valid_in = '0;
    adv(11);
    @(negedge clk_in);
    check_resp("after_dbz", 4'b0001, 2'd0, 8'd3, 8'd2, 1'b0);
    adv(1);

    // Busy lockout: requester 3 arrives while requester 0 is dividing
    req_valid_in = 4'b0001;
    dividend_in  = {8'd0, 8'd0, 8'd0, 8'd77};
    divisor_in   = {8'd0, 8'd0, 8'd0, 8'd5};
    @(negedge clk_in);
    check("lock_ready0", 32'(req_ready_out), 32'h1);
    adv(1);
    req_valid_in = '0;
    adv(2);
    req_valid_in = 4'b1000;
    dividend_in  = {8'd250, 8'd0, 8'd0, 8'd77};
    divisor_in   = {8'd16, 8'd0, 8'd0, 8'd5};
    @(negedge clk_in);
    check("lock_ready_t3", 32'(req_ready_out), 32'd0);
    adv(5);
    @(negedge clk_in);
    check("lock_ready_t8", 32'(req_ready_out), 32'd0);
    adv(4);
    @(negedge clk_in);
    check("lock_ready_t12", 32'(req_ready_out), 32'd0);
    check_resp("lock_r0", 4'b0001, 2'd0, 8'd15, 8'd2, 1'b0);
    adv(1);
    @(negedge clk_in);
    check("lock_ready3", 32'(req_ready_out), 32'h8);
    adv(1);
    req_valid_in = '0;
    dividend_in  = '0;
    divisor_in   = '0;
    adv(11);
    @(negedge clk_in);
    check_resp("lock_r3", 4'b1000, 2'd3, 8'd15, 8'd10, 1'b0);
    adv(1);

    // Mid-operation reset during requester 2's 100/3
    req_valid_in = 4'b0100;
    dividend_in  = {8'd0, 8'd100, 8'd0, 8'd0};
    divisor_in   = {8'd0, 8'd3, 8'd0, 8'd0};
    @(negedge clk_in);
    check("mid_ready", 32'(req_ready_out), 32'h4);
    adv(1);
    req_valid_in = '0;
    adv(4);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("mid_busy_before", 32'(busy_out), 32'd1);
    adv(1);
    rst_in = 1'b0;
    @(negedge clk_in);
    check_resp("mid_reset", 4'b0000, 2'd0, 8'd0, 8'd0, 1'b0);
    check("mid_reset_busy", 32'(busy_out), 32'd0);
    seen = '0;
    for (int c = 0; c < 14; c++) begin
      adv(1);
      @(negedge clk_in);
      seen = seen | resp_valid_out;
    end
    check("mid_no_stale", 32'(seen), 32'd0);
    adv(1);
    req_valid_in = 4'b0001;
    dividend_in  = {8'd0, 8'd0, 8'd0, 8'd9};
    divisor_in   = {8'd0, 8'd0, 8'd0, 8'd2};
    @(negedge clk_in);
    check("fresh_ready", 32'(req_ready_out), 32'h1);
    adv(1);
    req_valid_in = '0;
    adv(11);
    @(negedge clk_in);
    check_resp("fresh", 4'b0001, 2'd0, 8'd4, 8'd1, 1'b0);
    adv(1);
    @(negedge clk_in);
    check("fresh_idle", 32'(busy_out), 32'd0);

    // Report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_arbiter.md
# divider_arbiter

Shares one iterative `divider` among `NUM_REQ` independent requesters with round-robin fairness. Each requester hands over an unsigned dividend/divisor pair with a valid/ready handshake. The arbiter queues nothing: it runs one division at a time and returns the result on a shared response bus tagged with a one-hot requester strobe. Divide-by-zero is caught before the divider and answered immediately. The block sits between compute stages (e.g. normalisation, coordinate scaling) and the single divider instance.

## Interface
- `WIDTH`, default 8: operand and result width in bits.
- `NUM_REQ`, default 4: number of requesters, at least 2.
- `clk_in` input, 1 bit: the single clock.
- `rst_in` input, 1 bit: synchronous, active-high reset.
- `req_valid_in` input, `NUM_REQ` bits: per-requester request valid.
- `dividend_in` input, `NUM_REQ`×`WIDTH` bits, packed: requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `divisor_in` input, `NUM_REQ`×`WIDTH` bits, packed the same way.
- `req_ready_out` output, `NUM_REQ` bits: one-hot accept. Combinational, high only in IDLE.
- `resp_valid_out` output, `NUM_REQ` bits: one-hot one-cycle result strobe for the owning requester.
- `resp_id_out` output, `$clog2(NUM_REQ)` bits: index of the owning requester.
- `quotient_out` output, `WIDTH` bits: result quotient.
- `remainder_out` output, `WIDTH` bits: result remainder.
- `div_by_zero_out` output, 1 bit: result came from a zero divisor.
- `busy_out` output, 1 bit: high whenever state ≠ IDLE.

## Operation
- States:
  - `IDLE`: waiting for a request.
  - `ISSUE`: starting the divider.
  - `WAIT`: division in progress.
  - `RESPOND`: presenting the result.
- **IDLE → accept.** When any `req_valid_in` bit is high, the winner is the first set bit searching upward from `last_grant+1`, wrapping modulo `NUM_REQ`.
  - `req_ready_out` is the winner's one-hot. The transfer happens in that same cycle.
  - On transfer: latch operands and the winner index, and set `last_grant` to the winner.
  - If the divisor is 0, go to `RESPOND` with quotient = all ones, remainder = dividend, dbz = 1.
  - Otherwise go to `ISSUE`.
- **ISSUE.** Drive the divider's `data_valid_in` high for exactly one cycle with the latched operands, then go to `WAIT`.
- **WAIT.** Hold until the divider's `data_valid_out` is seen. Then register its quotient and remainder with dbz = 0, and go to `RESPOND`.
- **RESPOND.** Assert `resp_valid_out[id]` for one cycle, then return to `IDLE`.
- **Held outputs.** `quotient_out`, `remainder_out`, `div_by_zero_out` and `resp_id_out` are registers. They keep their values after the strobe until the next response.
- **Fairness.** A requester that holds valid is served within `NUM_REQ` grants.
  - A requester may drop valid before it is accepted; nothing is recorded for it.
  - Operands are only sampled in the accept cycle.
- **No response backpressure.** A requester must be able to take its result in the strobe cycle.
- **Reset.**
  - State goes to `IDLE` and `last_grant` goes to `NUM_REQ-1`, so requester 0 has first priority.
  - All outputs go to 0.
  - The divider is reset by the same `rst_in`.
  - A reset mid-division discards the operation; no response is ever issued for it.

## Timing
- Accept in cycle t, non-zero divisor:
  - The divider start strobe is in t+1.
  - The divider result is valid in t+WIDTH+3.
  - `resp_valid_out` is in t+WIDTH+4, which is t+12 for WIDTH=8.
- Accept in cycle t, zero divisor: `resp_valid_out` is in t+1.
- The next accept is possible at the earliest in the cycle after the response strobe. Sustained throughput is one division per WIDTH+5 cycles.
- `req_ready_out` is 0 in every state except `IDLE`, so there is never a second accept while busy.
- Any divider `data_valid_out` seen outside `WAIT` is ignored (cannot occur unless there is a fault).

## Structure
- Shared package `divider_arbiter_pkg`: the `state_t` enum (`IDLE`, `ISSUE`, `WAIT`, `RESPOND`) and the all-ones constant for divide-by-zero.
- One sub-module: a single instance of the existing `divider`, with the same `WIDTH`, clocked by `clk_in` and reset by `rst_in`.
- The round-robin selector is an inline function or `always_comb` loop, not a separate module.

## Test plan
- **Single request.** Requester 2 sends 200/7 in cycle t.
  - `req_ready_out` = 0100 in t.
  - `resp_valid_out` = 0100 at t+12 with q=28, r=4, dbz=0, id=2.
- **Round-robin.** All four requesters hold valid continuously after reset.
  - Grants come in order 0,1,2,3,0.
  - Each requester receives exactly its own result (e.g. 100/10, 99/9, 50/3, 255/1).
- **Divide by zero.** Requester 1 sends 37/0.
  - Response at t+1: q=255, r=37, dbz=1.
  - No divider start pulse is issued.
  - The next request is accepted at t+2.
- **Busy lockout.** Requester 3 raises valid during `WAIT` of requester 0's division.
  - `req_ready_out` stays 0 until `IDLE`.
  - Requester 3 is then accepted without losing its operands.
- **Mid-operation reset.** Assert `rst_in` in cycle t+5 of a division.
  - All outputs are 0 and `busy_out` = 0 the next cycle.
  - No stale `resp_valid_out` appears.
  - A fresh 9/2 afterwards returns q=4, r=1.
